// File: rtl/pc_sequencer.sv
// Next-address controller for pc_block: chooses the next PC from sequential flow,
// branches, jumps, trap entry/return, stall and halt, and owns the trap state.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] curr_addr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        trap_req,
    input  logic        trap_ret,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] next_addr,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        in_trap,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic        in_trap_q, in_trap_d;
    logic        halted_q, halted_d;
    logic        misaligned;
    logic        fault;

    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        in_trap_d  = in_trap_q;
        next_addr  = curr_addr + 32'd4;
        misaligned = (jmp && (jmp_target[1:0] != 2'b00)) ||
                     (br_taken && (br_target[1:0] != 2'b00));
        fault      = trap_req || misaligned;

        case (state_q)
            S_BOOT: begin
                next_addr = RESET_VEC;
                state_d   = S_RUN;
            end
            S_HALT: begin
                next_addr = curr_addr;
                if (resume) state_d = S_RUN;
            end
            S_RUN: begin
                // Any fault raised while already in the handler is unrecoverable.
                if (fault && in_trap_q) begin
                    next_addr = curr_addr;
                    cause_d   = 2'd3;
                    state_d   = S_HALT;
                end else if (fault) begin
                    next_addr = TRAP_VEC;
                    epc_d     = curr_addr;
                    cause_d   = trap_req ? 2'd1 : 2'd2;
                    in_trap_d = 1'b1;
                end else if (trap_ret && in_trap_q) begin
                    next_addr = epc_q + 32'd4;
                    in_trap_d = 1'b0;
                    cause_d   = 2'd0;
                end else if (jmp) begin
                    next_addr = jmp_target;
                end else if (br_taken) begin
                    next_addr = br_target;
                end else if (halt_req) begin
                    next_addr = curr_addr;
                    state_d   = S_HALT;
                end else if (stall) begin
                    next_addr = curr_addr;
                end
            end
            default: begin
                next_addr = RESET_VEC;
                state_d   = S_BOOT;
            end
        endcase

        // Reset overrides everything combinationally so pc_block loads RESET_VEC.
        if (rst) next_addr = RESET_VEC;
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BOOT;
            epc_q     <= 32'd0;
            cause_q   <= 2'd0;
            in_trap_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            in_trap_q <= in_trap_d;
            halted_q  <= halted_d;
        end
    end

    assign epc     = epc_q;
    assign cause   = cause_q;
    assign in_trap = in_trap_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural pc_block register closes the loop, directed
// scenarios check literal addresses, and a random run is checked against a reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] curr_addr;
    logic        stall, br_taken, jmp, trap_req, trap_ret, halt_req, resume;
    logic [31:0] br_target, jmp_target;
    logic [31:0] next_addr, epc;
    logic [1:0]  cause;
    logic        in_trap, halted;

    logic        force_en = 1'b0;
    logic [31:0] force_val = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: mode flags plus the architectural trap registers.
    logic        m_boot, m_halt, m_in_trap;
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    logic [31:0] e_next, n_epc;
    logic [1:0]  n_cause;
    logic        n_boot, n_halt, n_in_trap;

    pc_sequencer #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk(clk), .rst(rst), .curr_addr(curr_addr), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
        .trap_req(trap_req), .trap_ret(trap_ret), .halt_req(halt_req), .resume(resume),
        .next_addr(next_addr), .epc(epc), .cause(cause), .in_trap(in_trap), .halted(halted)
    );

    always #5 clk = ~clk;

    // pc_block stand-in; force lets a scenario start from an arbitrary PC.
    always @(posedge clk) curr_addr <= force_en ? force_val : next_addr;

    function automatic void model_eval();
        logic bad_target;
        logic any_fault;
        n_epc = m_epc; n_cause = m_cause; n_in_trap = m_in_trap;
        n_boot = m_boot; n_halt = m_halt;
        e_next = m_pc + 32'd4;
        bad_target = (jmp && (jmp_target % 4 != 0)) || (br_taken && (br_target % 4 != 0));
        any_fault = trap_req || bad_target;
        if (rst) begin
            e_next = RESET_VEC; n_boot = 1'b1; n_halt = 1'b0;
            n_epc = 32'd0; n_cause = 2'd0; n_in_trap = 1'b0;
        end else if (m_boot) begin
            e_next = RESET_VEC; n_boot = 1'b0;
        end else if (m_halt) begin
            e_next = m_pc;
            if (resume) n_halt = 1'b0;
        end else if (any_fault && m_in_trap) begin
            e_next = m_pc; n_cause = 2'd3; n_halt = 1'b1;
        end else if (any_fault) begin
            e_next = TRAP_VEC; n_epc = m_pc; n_in_trap = 1'b1;
            n_cause = trap_req ? 2'd1 : 2'd2;
        end else if (trap_ret && m_in_trap) begin
            e_next = m_epc + 32'd4; n_in_trap = 1'b0; n_cause = 2'd0;
        end else if (jmp) e_next = jmp_target;
        else if (br_taken) e_next = br_target;
        else if (halt_req) begin
            e_next = m_pc; n_halt = 1'b1;
        end else if (stall) e_next = m_pc;
    endfunction

    // Advance one clock: commit the model at the edge, return 1 time unit later.
    task automatic tick();
        model_eval();
        @(posedge clk);
        m_pc = force_en ? force_val : e_next;
        m_epc = n_epc; m_cause = n_cause; m_in_trap = n_in_trap;
        m_boot = n_boot; m_halt = n_halt;
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; br_taken = 0; jmp = 0; trap_req = 0; trap_ret = 0;
        halt_req = 0; resume = 0; br_target = 0; jmp_target = 0;
    endtask

    task automatic load_pc(input logic [31:0] val);
        force_en = 1'b1; force_val = val;
        tick();
        force_en = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        n_cmp++; if (next_addr !== RESET_VEC) begin n_bad++; $display("FAIL reset_next: got %h want %h", next_addr, RESET_VEC); end
        tick(); tick();
        n_cmp++; if ({epc, cause, in_trap, halted} !== 36'd0) begin
            n_bad++; $display("FAIL reset_regs: epc %h cause %0d in_trap %b halted %b want all 0", epc, cause, in_trap, halted); end
        rst = 1'b0;
        #1;
        n_cmp++; if (next_addr !== RESET_VEC) begin n_bad++; $display("FAIL boot_next: got %h want %h", next_addr, RESET_VEC); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (curr_addr !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_pc%0d: got %h want %h", i, curr_addr, 4 * i); end
        end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL seq_halted: got %b want 0", halted); end
    endtask

    task automatic test_branch_jump_stall();
        tick();
        n_cmp++; if (curr_addr !== 32'h10) begin n_bad++; $display("FAIL bj_start: got %h want 10", curr_addr); end
        br_taken = 1; br_target = 32'h40; jmp = 1; jmp_target = 32'h80;
        #1;
        n_cmp++; if (next_addr !== 32'h80) begin n_bad++; $display("FAIL jmp_beats_br: got %h want 80", next_addr); end
        tick();
        clear_inputs();
        n_cmp++; if (curr_addr !== 32'h80) begin n_bad++; $display("FAIL jmp_pc: got %h want 80", curr_addr); end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (curr_addr !== 32'h80) begin n_bad++; $display("FAIL stall_hold%0d: got %h want 80", i, curr_addr); end
        end
        stall = 0;
        tick();
        n_cmp++; if (curr_addr !== 32'h84) begin n_bad++; $display("FAIL stall_release: got %h want 84", curr_addr); end
        stall = 1; jmp = 1; jmp_target = 32'h200;
        #1;
        n_cmp++; if (next_addr !== 32'h200) begin n_bad++; $display("FAIL stall_jmp: got %h want 200", next_addr); end
        clear_inputs();
    endtask

    task automatic test_trap_round_trip();
        load_pc(32'h24);
        trap_req = 1;
        #1;
        n_cmp++; if (next_addr !== TRAP_VEC) begin n_bad++; $display("FAIL trap_next: got %h want %h", next_addr, TRAP_VEC); end
        tick();
        trap_req = 0;
        n_cmp++; if ({curr_addr, epc, cause, in_trap} !== {32'h100, 32'h24, 2'd1, 1'b1}) begin
            n_bad++; $display("FAIL trap_entry: pc %h epc %h cause %0d in_trap %b want 100 24 1 1", curr_addr, epc, cause, in_trap); end
        tick(); tick();
        n_cmp++; if (curr_addr !== 32'h108) begin n_bad++; $display("FAIL handler_seq: got %h want 108", curr_addr); end
        trap_ret = 1;
        #1;
        n_cmp++; if (next_addr !== 32'h28) begin n_bad++; $display("FAIL ret_next: got %h want 28", next_addr); end
        tick();
        trap_ret = 0;
        n_cmp++; if ({curr_addr, cause, in_trap} !== {32'h28, 2'd0, 1'b0}) begin
            n_bad++; $display("FAIL ret_state: pc %h cause %0d in_trap %b want 28 0 0", curr_addr, cause, in_trap); end
    endtask

    task automatic test_misaligned_double_fault();
        load_pc(32'h30);
        jmp = 1; jmp_target = 32'h202;
        tick();
        clear_inputs();
        n_cmp++; if ({curr_addr, epc, cause, in_trap} !== {32'h100, 32'h30, 2'd2, 1'b1}) begin
            n_bad++; $display("FAIL misaligned: pc %h epc %h cause %0d in_trap %b want 100 30 2 1", curr_addr, epc, cause, in_trap); end
        trap_req = 1;
        #1;
        n_cmp++; if (next_addr !== 32'h100) begin n_bad++; $display("FAIL dbl_next: got %h want 100", next_addr); end
        tick();
        trap_req = 0;
        n_cmp++; if ({curr_addr, epc, cause, halted} !== {32'h100, 32'h30, 2'd3, 1'b1}) begin
            n_bad++; $display("FAIL dbl_fault: pc %h epc %h cause %0d halted %b want 100 30 3 1", curr_addr, epc, cause, halted); end
        rst = 1; tick(); rst = 0; tick();
    endtask

    task automatic test_halt_resume();
        load_pc(32'h50);
        halt_req = 1;
        tick();
        halt_req = 0;
        n_cmp++; if ({curr_addr, halted} !== {32'h50, 1'b1}) begin
            n_bad++; $display("FAIL halt_enter: pc %h halted %b want 50 1", curr_addr, halted); end
        for (int i = 0; i < 5; i++) begin
            jmp = i[0]; jmp_target = 32'h300; trap_req = ~i[0];
            #1;
            n_cmp++; if (next_addr !== 32'h50) begin n_bad++; $display("FAIL halt_hold%0d: got %h want 50", i, next_addr); end
            tick();
            n_cmp++; if ({cause, halted} !== {2'd0, 1'b1}) begin
                n_bad++; $display("FAIL halt_ignore%0d: cause %0d halted %b want 0 1", i, cause, halted); end
        end
        clear_inputs();
        resume = 1;
        tick();
        resume = 0;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL resume_halted: got %b want 0", halted); end
        tick();
        n_cmp++; if (curr_addr !== 32'h54) begin n_bad++; $display("FAIL resume_pc: got %h want 54", curr_addr); end
        halt_req = 1; tick(); halt_req = 0;
        rst = 1;
        #1;
        n_cmp++; if (next_addr !== RESET_VEC) begin n_bad++; $display("FAIL halt_rst_next: got %h want 0", next_addr); end
        tick();
        rst = 0;
        n_cmp++; if ({curr_addr, halted} !== {32'h0, 1'b0}) begin
            n_bad++; $display("FAIL halt_rst: pc %h halted %b want 0 0", curr_addr, halted); end
        tick(); tick();
        n_cmp++; if (curr_addr !== 32'h4) begin n_bad++; $display("FAIL post_boot: got %h want 4", curr_addr); end
    endtask

    task automatic test_wrap_stray_ret();
        load_pc(32'hFFFF_FFFC);
        #1;
        n_cmp++; if (next_addr !== 32'h0) begin n_bad++; $display("FAIL wrap: got %h want 0", next_addr); end
        tick();
        trap_ret = 1;
        #1;
        n_cmp++; if (next_addr !== 32'h4) begin n_bad++; $display("FAIL stray_ret_next: got %h want 4", next_addr); end
        tick();
        trap_ret = 0;
        n_cmp++; if ({curr_addr, epc, in_trap} !== {32'h4, m_epc, 1'b0}) begin
            n_bad++; $display("FAIL stray_ret: pc %h epc %h in_trap %b want 4 %h 0", curr_addr, epc, in_trap, m_epc); end
    endtask

    task automatic test_random();
        int errs_here;
        errs_here = 0;
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 600; c++) begin
            stall      = ($urandom_range(0, 3) == 0);
            br_taken   = ($urandom_range(0, 4) == 0);
            jmp        = ($urandom_range(0, 6) == 0);
            trap_req   = ($urandom_range(0, 19) == 0);
            trap_ret   = ($urandom_range(0, 5) == 0);
            halt_req   = ($urandom_range(0, 29) == 0);
            resume     = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            br_target  = $urandom() & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jmp_target = $urandom() & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            #1;
            model_eval();
            n_cmp++;
            if (next_addr !== e_next || curr_addr !== m_pc || epc !== m_epc || cause !== m_cause
                || in_trap !== m_in_trap || halted !== m_halt) begin
                n_bad++; errs_here++;
                if (errs_here <= 10)
                    $display("FAIL rand_c%0d: next %h pc %h epc %h cause %0d trap %b halt %b want %h %h %h %0d %b %b",
                             c, next_addr, curr_addr, epc, cause, in_trap, halted,
                             e_next, m_pc, m_epc, m_cause, m_in_trap, m_halt);
            end
            tick();
        end
        clear_inputs();
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_branch_jump_stall();
        test_trap_round_trip();
        test_misaligned_double_fault();
        test_halt_resume();
        test_wrap_stray_ret();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-address controller for pc_block in the single-cycle core. Each cycle it computes next_addr from the current PC and the core's control-flow inputs: sequential, branch, jump, trap entry, trap return, stall and halt. It holds trap state (in_trap, epc, cause) and a small boot/run/halt state machine, so pc_block needs no control logic of its own.

Parameters:
RESET_VEC, 32'h0000_0000, address driven on next_addr during reset and in BOOT.
TRAP_VEC, 32'h0000_0100, trap handler entry address.

Ports:
clk  input  1  rising-edge clock, shared with pc_block
rst  input  1  synchronous active-high reset
curr_addr  input  32  current PC, from pc_block
stall  input  1  hold PC this cycle
br_taken  input  1  conditional branch resolved taken
br_target  input  32  branch target
jmp  input  1  unconditional jump
jmp_target  input  32  jump target
trap_req  input  1  external or illegal-instruction trap request
trap_ret  input  1  return from trap handler
halt_req  input  1  enter HALT
resume  input  1  leave HALT
next_addr  output  32  to pc_block next_addr
epc  output  32  saved PC of the trapping instruction
cause  output  2  0 none, 1 trap_req, 2 misaligned target, 3 double fault
in_trap  output  1  inside the trap handler
halted  output  1  state == HALT

Behaviour:
- One clock domain; reset is synchronous and active-high; clock port is clk and reset port is rst.
- next_addr is combinational from curr_addr, inputs and registered state. All other outputs are registered.
- rst high: next_addr = RESET_VEC. At the edge: state <= BOOT, epc <= 0, cause <= 0, in_trap <= 0. halted is 0 after the reset edge.
- States are BOOT, RUN and HALT.
- BOOT: next_addr = RESET_VEC and all inputs are ignored. Moves to RUN unconditionally after 1 cycle.
- HALT: next_addr = curr_addr, halted = 1. resume moves to RUN at the next edge. While halted, only resume and rst are honoured.
- RUN priority (highest first), evaluated each cycle:
  1. trap_req with in_trap = 1: double fault. next_addr = curr_addr, cause <= 3, state <= HALT, epc unchanged.
  2. trap_req: next_addr = TRAP_VEC, epc <= curr_addr, cause <= 1, in_trap <= 1.
  3. jmp with jmp_target[1:0] != 0, or br_taken with br_target[1:0] != 0: misaligned. If in_trap = 0, treat as trap entry with cause <= 2. If in_trap = 1, treat as double fault (cause 3, HALT).
  4. trap_ret with in_trap = 1: next_addr = epc + 4, in_trap <= 0, cause <= 0. trap_ret with in_trap = 0 is ignored and falls through.
  5. jmp: next_addr = jmp_target. jmp beats br_taken when both are asserted.
  6. br_taken: next_addr = br_target.
  7. halt_req: next_addr = curr_addr, state <= HALT.
  8. stall: next_addr = curr_addr.
  9. Default: next_addr = curr_addr + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect targets take effect in one cycle: curr_addr equals the target after the next edge.
- stall does not block higher-priority items: a redirect, trap or trap_ret in a stalled cycle still wins.
- rst asserted mid-trap or mid-halt aborts everything and returns to BOOT.

Test Plan:
- Reset and sequential: rst = 1 for 2 cycles, then release. next_addr = 0 during reset and BOOT; curr_addr then runs 0, 4, 8, 0xC; halted = 0.
- Branch, jump and stall: at curr_addr = 0x10, assert br_taken with br_target = 0x40 and jmp with jmp_target = 0x80 together -> next PC = 0x80. Then stall for 3 cycles -> PC stays 0x80. Release -> 0x84.
- Trap round trip: trap_req at PC 0x24 -> PC 0x100, epc = 0x24, cause = 1, in_trap = 1. Two sequential cycles -> PC 0x108. trap_ret -> PC 0x28, in_trap = 0, cause = 0.
- Misaligned and double fault: jmp with jmp_target = 0x202 at PC 0x30 -> PC 0x100, epc = 0x30, cause = 2. A second trap_req inside the handler -> PC holds, cause = 3, halted = 1.
- Halt and resume: halt_req at PC 0x50 -> PC holds at 0x50 for 5 cycles while jmp and trap_req toggle. resume -> PC 0x54. Asserting rst while halted -> PC 0, state BOOT.
- Wrap and stray return: curr_addr = 0xFFFF_FFFC with no controls -> next_addr = 0. trap_ret with in_trap = 0 -> sequential +4, epc unchanged.
